alu_ctrl_pipe: RTL and testbench
================================

# alu_ctrl_pipe

Pipelined, parametrised ALU control unit for the pipelined LEGv8 datapath. Sits between the ID/EX boundary and the ALU: accepts `{ALUop, Opcode}` under a valid/ready handshake, decodes them to an ALU control word, and registers the result. Adds LSR and an iterative MUL that occupies the unit for `MUL_CYCLES` cycles. Supports back-pressure from EX, pipeline flush on branch mispredict, and illegal-opcode flagging.

## Interface
- `OPC_W`, 11, opcode field width; decode compares the top 11 bits, and `OPC_W` must be at least 11.
- `CTRL_W`, 4, ALU control width; must be at least 4; bits above [3:0] are driven 0.
- `MUL_CYCLES`, 4, MUL occupancy in cycles; must be at least 1.

Ports:
- `CLK` in 1: sole clock, rising edge.
- `Reset_L` in 1: asynchronous, active-low reset.
- `InValid` in 1: upstream request valid.
- `InReady` out 1: unit can accept this cycle.
- `ALUop` in 2: main-control ALU op class.
- `Opcode` in `OPC_W`: instruction opcode field.
- `Flush` in 1: synchronous kill of all in-flight and pending work.
- `OutValid` out 1: `ALUCtrl` is valid.
- `OutReady` in 1: EX stage consumes the output.
- `ALUCtrl` out `CTRL_W`: registered ALU control word.
- `Busy` out 1: MUL sequence in progress.
- `IllegalOp` out 1: registered with `ALUCtrl`; the decoded op was unsupported.

## Operation
- Decode (combinational, on accepted input):
  - `ALUop` 00 (D-type) → 0010.
  - `ALUop` 01 (CBZ) → 0111.
  - `ALUop` 11 → 1111 with the illegal flag set.
- `ALUop` 10 (R/I-type), by opcode:
  - ADD 10001011000 → 0010.
  - SUB 11001011000 → 0110.
  - AND 10001010000 → 0000.
  - ORR 10101010000 → 0001.
  - ORRI (`Opcode[10:1]`=1011001000) → 0001.
  - LSL 11010011011 → 0011.
  - LSR 11010011010 → 0100.
  - MUL 10011011000 → 1000, multi-cycle.
  - Any other opcode → 1111 with the illegal flag set.
- FSM states:
  - IDLE: unit can accept input.
  - MULWAIT: MUL counting down.
- `InReady` = `Reset_L` && state==IDLE && !`Flush` && (!`OutValid` || `OutReady`).
- Accept = `InValid` && `InReady`.
- IDLE, accept, non-MUL op:
  - Next edge: `ALUCtrl`/`IllegalOp` load the decode and `OutValid`=1.
  - State stays IDLE.
- IDLE, accept, MUL op, `MUL_CYCLES`=1: handled exactly like a non-MUL op.
- IDLE, accept, MUL op, `MUL_CYCLES`>1:
  - Counter loads `MUL_CYCLES`-2, `Busy`=1, state goes to MULWAIT.
  - `OutValid` goes 0 at the same edge if the previous output was consumed.
- MULWAIT:
  - Counter decrements each cycle.
  - On the edge where the counter is 0: `ALUCtrl`=1000, `IllegalOp`=0, `OutValid`=1, `Busy`=0, state goes to IDLE.
- Output handshake:
  - Output is consumed when `OutValid` && `OutReady`.
  - When consumed with no new result loading, `OutValid` goes to 0 next edge.
  - While `OutValid` && !`OutReady`, `ALUCtrl` and `IllegalOp` are held stable.
- Flush (priority over everything):
  - Next edge: `OutValid`=0, `Busy`=0, counter=0, state goes to IDLE.
  - `ALUCtrl` keeps its last value.
  - Input presented in the flush cycle is not accepted.
- Counter width: `$clog2(MUL_CYCLES+1)`, minimum 1 bit; no wrap, because it only decrements while nonzero.

## Timing
- Reset (asynchronous assert, synchronous release on `CLK`):
  - `OutValid`=0, `Busy`=0, `IllegalOp`=0.
  - `ALUCtrl`=1 (zero-extended to `CTRL_W`).
  - State IDLE, counter 0.
  - `InReady`=0 while `Reset_L` is low.
- Latency, accept edge to `OutValid` high:
  - 1 cycle for non-MUL ops.
  - `MUL_CYCLES` cycles for MUL.
- Throughput:
  - Non-MUL: one op per cycle with `OutReady` held high.
  - MUL: blocks input for `MUL_CYCLES`-1 extra cycles.
- `InReady` depends combinationally on `OutReady` and `Flush`; there is no other combinational input-to-output path.
- Simultaneous events:
  - Consume and accept in the same cycle: the new result replaces the old one with `OutValid` staying 1.
  - Flush together with the MUL completion edge: flush wins and no output is produced.
- Reset asserted mid-MUL: immediately returns all registers to their reset values.

## Test plan
- Reset with `Reset_L` low for 3 cycles, then release:
  - During and after: `OutValid`=0, `ALUCtrl`=0001, `Busy`=0.
  - `InReady`=0 during reset and 1 after release.
- Back-to-back decode, `OutReady`=1: ADD, SUB, AND, ORR, ORRI(1011001000x), LSL, LSR on consecutive cycles → `ALUCtrl` 0010, 0110, 0000, 0001, 0001, 0011, 0100 on consecutive cycles, each one cycle after acceptance.
- MUL with `MUL_CYCLES`=4:
  - `Busy`=1 and `InReady`=0 for 3 cycles.
  - Then `OutValid`=1, `ALUCtrl`=1000, `Busy`=0, with `OutValid` exactly 4 cycles after acceptance.
- Back-pressure: ADD accepted with `OutReady`=0 for 5 cycles:
  - `OutValid` stays 1, `ALUCtrl` holds 0010, and `InReady`=0 throughout.
  - Raising `OutReady` consumes the result and re-enables `InReady` in the same cycle.
- Flush mid-MUL: assert `Flush` 2 cycles into a MUL → next edge `Busy`=0 and `OutValid`=0, and no 1000 result ever appears.
- Illegal ops:
  - `ALUop`=10 with opcode 11111111111 → `ALUCtrl`=1111, `IllegalOp`=1.
  - `ALUop`=11 → same result.
  - A following ADD → `IllegalOp`=0.

Source files
------------

// File: rtl/alu_ctrl_pipe.sv
// -----------------------------------------------------------------------------
// alu_ctrl_pipe
//
// Pipelined ALU control unit for the LEGv8 datapath. Sits between the ID/EX
// boundary and the ALU. It takes {ALUop, Opcode} under a valid/ready handshake,
// decodes the pair into an ALU control word, and registers the result toward EX.
// MUL is iterative and holds the unit for MUL_CYCLES cycles. A branch
// mispredict Flush kills any work that is in flight. Unsupported encodings
// produce the 1111 control word with IllegalOp set.
//
// Parameters
//   OPC_W      opcode field width (>= 11). Decode uses the top 11 bits.
//   CTRL_W     ALU control width (>= 4). Bits above [3:0] are driven 0.
//   MUL_CYCLES MUL occupancy in cycles (>= 1).
//
// Ports
//   CLK       in   sole clock, rising edge
//   Reset_L   in   asynchronous active-low reset, released synchronously
//   InValid   in   upstream request valid
//   InReady   out  unit can accept this cycle (combinational)
//   ALUop     in   main-control ALU op class
//   Opcode    in   instruction opcode field
//   Flush     in   synchronous kill of all in-flight and pending work
//   OutValid  out  ALUCtrl is valid (registered)
//   OutReady  in   EX stage consumes the output
//   ALUCtrl   out  registered ALU control word
//   Busy      out  MUL sequence in progress (registered)
//   IllegalOp out  registered with ALUCtrl; the decoded op was unsupported
// -----------------------------------------------------------------------------
module alu_ctrl_pipe #(
   parameter int OPC_W      = 11,
   parameter int CTRL_W     = 4,
   parameter int MUL_CYCLES = 4
) (
   input  logic              CLK,
   input  logic              Reset_L,
   input  logic              InValid,
   output logic              InReady,
   input  logic [1:0]        ALUop,
   input  logic [OPC_W-1:0]  Opcode,
   input  logic              Flush,
   output logic              OutValid,
   input  logic              OutReady,
   output logic [CTRL_W-1:0] ALUCtrl,
   output logic              Busy,
   output logic              IllegalOp
);

   // The counter only has to reach MUL_CYCLES-2. One bit is always kept so the
   // vector stays legal when MUL_CYCLES is 1.
   localparam int CNT_W = (MUL_CYCLES < 2) ? 1 : $clog2(MUL_CYCLES + 1);

   // When MUL_CYCLES is 1, MUL takes the single-cycle path like any other op.
   localparam bit MUL_MULTI = (MUL_CYCLES > 1);

   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LOAD = MUL_MULTI ? CNT_W'(MUL_CYCLES - 2) : CNT_W'(0);

   // ALU control encodings
   localparam logic [3:0] CTRL_AND = 4'b0000;
   localparam logic [3:0] CTRL_ORR = 4'b0001;
   localparam logic [3:0] CTRL_ADD = 4'b0010;
   localparam logic [3:0] CTRL_LSL = 4'b0011;
   localparam logic [3:0] CTRL_LSR = 4'b0100;
   localparam logic [3:0] CTRL_SUB = 4'b0110;
   localparam logic [3:0] CTRL_CBZ = 4'b0111;
   localparam logic [3:0] CTRL_MUL = 4'b1000;
   localparam logic [3:0] CTRL_ILL = 4'b1111;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_MULWAIT = 1'b1
   } state_t;

   typedef struct packed {
      logic       ill;
      logic       mul;
      logic [3:0] ctrl;
   } dec_t;

   // Maps {ALUop, opcode} to a control word plus the illegal and multi-cycle flags
   function automatic dec_t decode_fn(input logic [1:0] op, input logic [10:0] opc);
      dec_t d;
      d = '{ill: 1'b1, mul: 1'b0, ctrl: CTRL_ILL};
      case (op)
         2'b00: d = '{ill: 1'b0, mul: 1'b0, ctrl: CTRL_ADD};
         2'b01: d = '{ill: 1'b0, mul: 1'b0, ctrl: CTRL_CBZ};
         2'b10: begin
            casez (opc)
               11'b10001011000: d = '{ill: 1'b0, mul: 1'b0, ctrl: CTRL_ADD};
               11'b11001011000: d = '{ill: 1'b0, mul: 1'b0, ctrl: CTRL_SUB};
               11'b10001010000: d = '{ill: 1'b0, mul: 1'b0, ctrl: CTRL_AND};
               11'b10101010000: d = '{ill: 1'b0, mul: 1'b0, ctrl: CTRL_ORR};
               11'b1011001000?: d = '{ill: 1'b0, mul: 1'b0, ctrl: CTRL_ORR};
               11'b11010011011: d = '{ill: 1'b0, mul: 1'b0, ctrl: CTRL_LSL};
               11'b11010011010: d = '{ill: 1'b0, mul: 1'b0, ctrl: CTRL_LSR};
               11'b10011011000: d = '{ill: 1'b0, mul: 1'b1, ctrl: CTRL_MUL};
               default:         d = '{ill: 1'b1, mul: 1'b0, ctrl: CTRL_ILL};
            endcase
         end
         default: d = '{ill: 1'b1, mul: 1'b0, ctrl: CTRL_ILL};
      endcase
      return d;
   endfunction

   state_t            state_r;
   state_t            state_nxt_s;
   logic [CNT_W-1:0]  cnt_r;
   logic [CNT_W-1:0]  cnt_nxt_s;
   logic              out_valid_r;
   logic              out_valid_nxt_s;
   logic              busy_r;
   logic              busy_nxt_s;
   logic [CTRL_W-1:0] ctrl_r;
   logic [CTRL_W-1:0] ctrl_nxt_s;
   logic              ill_r;
   logic              ill_nxt_s;

   logic [10:0]       opc_top_s;
   dec_t              dec_s;
   logic              in_ready_s;
   logic              accept_s;
   logic              consume_s;
   logic              mul_start_s;
   logic              cnt_zero_s;

   assign opc_top_s = Opcode[OPC_W-1 -: 11];
   assign dec_s     = decode_fn(ALUop, opc_top_s);

   // Input is held off for three reasons: during reset, while MUL runs, and in
   // a Flush cycle. It is also held off while an unconsumed result is parked
   // on the output.
   assign in_ready_s  = Reset_L && (state_r == ST_IDLE) && !Flush && (!out_valid_r || OutReady);
   assign accept_s    = InValid && in_ready_s;
   assign consume_s   = out_valid_r && OutReady;
   assign mul_start_s = accept_s && dec_s.mul && MUL_MULTI;
   assign cnt_zero_s  = (cnt_r == CNT_ZERO);

   // State register plus all registered outputs
   always_ff @(posedge CLK or negedge Reset_L) begin
      if (!Reset_L) begin
         state_r     <= ST_IDLE;
         cnt_r       <= CNT_ZERO;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         ctrl_r      <= CTRL_W'(1);
         ill_r       <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         cnt_r       <= cnt_nxt_s;
         out_valid_r <= out_valid_nxt_s;
         busy_r      <= busy_nxt_s;
         ctrl_r      <= ctrl_nxt_s;
         ill_r       <= ill_nxt_s;
      end
   end

   // Next-state logic: IDLE <-> MULWAIT, and Flush always returns to IDLE
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (Flush) begin
               state_nxt_s = ST_IDLE;
            end else if (mul_start_s) begin
               state_nxt_s = ST_MULWAIT;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_MULWAIT: begin
            if (Flush) begin
               state_nxt_s = ST_IDLE;
            end else if (cnt_zero_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_MULWAIT;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Output/datapath next values. The branches are in priority order: Flush,
   // then MUL progress, then MUL start, then a new single-cycle result, then
   // a plain consume.
   always_comb begin
      out_valid_nxt_s = out_valid_r;
      busy_nxt_s      = busy_r;
      cnt_nxt_s       = cnt_r;
      ctrl_nxt_s      = ctrl_r;
      ill_nxt_s       = ill_r;
      if (Flush) begin
         // Flush keeps ALUCtrl/IllegalOp so EX never sees the word glitch.
         out_valid_nxt_s = 1'b0;
         busy_nxt_s      = 1'b0;
         cnt_nxt_s       = CNT_ZERO;
      end else if (state_r == ST_MULWAIT) begin
         if (cnt_zero_s) begin
            ctrl_nxt_s      = CTRL_W'(CTRL_MUL);
            ill_nxt_s       = 1'b0;
            out_valid_nxt_s = 1'b1;
            busy_nxt_s      = 1'b0;
         end else begin
            cnt_nxt_s       = cnt_r - CNT_ONE;
         end
      end else if (mul_start_s) begin
         // Acceptance implies any parked result is consumed this cycle.
         cnt_nxt_s       = CNT_LOAD;
         busy_nxt_s      = 1'b1;
         out_valid_nxt_s = 1'b0;
      end else if (accept_s) begin
         ctrl_nxt_s      = CTRL_W'(dec_s.ctrl);
         ill_nxt_s       = dec_s.ill;
         out_valid_nxt_s = 1'b1;
      end else if (consume_s) begin
         out_valid_nxt_s = 1'b0;
      end else begin
         out_valid_nxt_s = out_valid_r;
      end
   end

   assign InReady   = in_ready_s;
   assign OutValid  = out_valid_r;
   assign Busy      = busy_r;
   assign ALUCtrl   = ctrl_r;
   assign IllegalOp = ill_r;

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
module tb_alu_ctrl_pipe;

   logic        CLK;
   logic        Reset_L;
   logic        InValid;
   logic        InReady;
   logic [1:0]  ALUop;
   logic [10:0] Opcode;
   logic        Flush;
   logic        OutValid;
   logic        OutReady;
   logic [3:0]  ALUCtrl;
   logic        Busy;
   logic        IllegalOp;

   int n_cmp = 0;
   int n_err = 0;

   // expected {illegal, ctrl} in output order
   logic [4:0] exp_q[$];

   typedef struct {
      logic [1:0]  op;
      logic [10:0] opc;
      logic [3:0]  ctrl;
      logic        ill;
   } vec_t;

   localparam int NV = 12;
   vec_t tbl[NV];

   localparam logic [10:0] OPC_ADD = 11'b10001011000;
   localparam logic [10:0] OPC_MUL = 11'b10011011000;

   alu_ctrl_pipe #(.OPC_W(11), .CTRL_W(4), .MUL_CYCLES(4)) dut (
      .CLK      (CLK),
      .Reset_L  (Reset_L),
      .InValid  (InValid),
      .InReady  (InReady),
      .ALUop    (ALUop),
      .Opcode   (Opcode),
      .Flush    (Flush),
      .OutValid (OutValid),
      .OutReady (OutReady),
      .ALUCtrl  (ALUCtrl),
      .Busy     (Busy),
      .IllegalOp(IllegalOp)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // settle after input changes, then pop/compare if a consume happens at the next edge
   task automatic sample();
      logic [4:0] e;
      #1;
      if (OutValid && OutReady) begin
         chk("sb_expect_pending", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_ctrl", 32'(ALUCtrl), 32'(e[3:0]));
            chk("sb_illegal", 32'(IllegalOp), 32'(e[4]));
         end
      end
   endtask

   task automatic send(input logic [1:0] op, input logic [10:0] opc,
                       input logic [3:0] ec, input logic ei);
      InValid = 1'b1;
      ALUop   = op;
      Opcode  = opc;
      exp_q.push_back({ei, ec});
   endtask

   task automatic present_mul();
      InValid = 1'b1;
      ALUop   = 2'b10;
      Opcode  = OPC_MUL;
   endtask

   initial begin
      tbl[0]  = '{2'b10, 11'b10001011000, 4'b0010, 1'b0}; // ADD
      tbl[1]  = '{2'b10, 11'b11001011000, 4'b0110, 1'b0}; // SUB
      tbl[2]  = '{2'b10, 11'b10001010000, 4'b0000, 1'b0}; // AND
      tbl[3]  = '{2'b10, 11'b10101010000, 4'b0001, 1'b0}; // ORR
      tbl[4]  = '{2'b10, 11'b10110010001, 4'b0001, 1'b0}; // ORRI
      tbl[5]  = '{2'b10, 11'b11010011011, 4'b0011, 1'b0}; // LSL
      tbl[6]  = '{2'b10, 11'b11010011010, 4'b0100, 1'b0}; // LSR
      tbl[7]  = '{2'b10, 11'b11111111111, 4'b1111, 1'b1}; // unknown R-type
      tbl[8]  = '{2'b11, 11'b10001011000, 4'b1111, 1'b1}; // ALUop 11
      tbl[9]  = '{2'b10, 11'b10001011000, 4'b0010, 1'b0}; // ADD clears illegal
      tbl[10] = '{2'b00, 11'b00000000000, 4'b0010, 1'b0}; // D-type
      tbl[11] = '{2'b01, 11'b01010101010, 4'b0111, 1'b0}; // CBZ

      Reset_L  = 1'b0;
      InValid  = 1'b0;
      ALUop    = 2'b00;
      Opcode   = 11'd0;
      Flush    = 1'b0;
      OutReady = 1'b0;

      // ---- reset held for 3 cycles ----
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         #1;
         chk("rst_outvalid", 32'(OutValid), 32'd0);
         chk("rst_aluctrl", 32'(ALUCtrl), 32'd1);
         chk("rst_busy", 32'(Busy), 32'd0);
         chk("rst_inready", 32'(InReady), 32'd0);
         chk("rst_illegal", 32'(IllegalOp), 32'd0);
      end
      Reset_L = 1'b1;
      #1;
      chk("rel_inready", 32'(InReady), 32'd1);
      @(negedge CLK);
      #1;
      chk("rel_outvalid", 32'(OutValid), 32'd0);
      chk("rel_aluctrl", 32'(ALUCtrl), 32'd1);
      chk("rel_busy", 32'(Busy), 32'd0);
      @(negedge CLK);

      // ---- back-to-back decode table ----
      OutReady = 1'b1;
      for (int i = 0; i < NV; i++) begin
         send(tbl[i].op, tbl[i].opc, tbl[i].ctrl, tbl[i].ill);
         sample();
         chk("tbl_inready", 32'(InReady), 32'd1);
         chk("tbl_outvalid", 32'(OutValid), 32'(i > 0));
         @(negedge CLK);
      end
      InValid = 1'b0;
      sample();
      chk("tbl_last_valid", 32'(OutValid), 32'd1);
      @(negedge CLK);
      sample();
      chk("tbl_drain_valid", 32'(OutValid), 32'd0);
      @(negedge CLK);

      // ---- MUL, 4 cycles, ADD waiting behind it ----
      send(2'b10, OPC_MUL, 4'b1000, 1'b0);
      sample();
      chk("mul_accept_ready", 32'(InReady), 32'd1);
      @(negedge CLK);
      InValid = 1'b1;
      ALUop   = 2'b10;
      Opcode  = OPC_ADD;
      for (int k = 0; k < 3; k++) begin
         sample();
         chk("mul_busy", 32'(Busy), 32'd1);
         chk("mul_inready", 32'(InReady), 32'd0);
         chk("mul_outvalid", 32'(OutValid), 32'd0);
         @(negedge CLK);
      end
      exp_q.push_back({1'b0, 4'b0010});   // ADD accepted as MUL result is consumed
      sample();
      chk("mul_done_valid", 32'(OutValid), 32'd1);
      chk("mul_done_ctrl", 32'(ALUCtrl), 32'h8);
      chk("mul_done_busy", 32'(Busy), 32'd0);
      chk("mul_done_inready", 32'(InReady), 32'd1);
      @(negedge CLK);
      InValid = 1'b0;
      sample();
      chk("swap_valid", 32'(OutValid), 32'd1);
      @(negedge CLK);
      sample();
      chk("swap_drain", 32'(OutValid), 32'd0);
      @(negedge CLK);

      // ---- back-pressure ----
      send(2'b10, OPC_ADD, 4'b0010, 1'b0);
      sample();
      @(negedge CLK);
      InValid  = 1'b0;
      OutReady = 1'b0;
      for (int k = 0; k < 5; k++) begin
         sample();
         chk("bp_valid", 32'(OutValid), 32'd1);
         chk("bp_ctrl", 32'(ALUCtrl), 32'h2);
         chk("bp_inready", 32'(InReady), 32'd0);
         @(negedge CLK);
      end
      OutReady = 1'b1;
      sample();
      chk("bp_release_inready", 32'(InReady), 32'd1);
      @(negedge CLK);
      sample();
      chk("bp_drain", 32'(OutValid), 32'd0);
      @(negedge CLK);

      // ---- Flush 2 cycles into MUL ----
      present_mul();
      sample();
      @(negedge CLK);
      InValid = 1'b0;
      sample();
      chk("fl_busy_before", 32'(Busy), 32'd1);
      @(negedge CLK);
      Flush = 1'b1;
      sample();
      @(negedge CLK);
      Flush = 1'b0;
      sample();
      chk("fl_busy", 32'(Busy), 32'd0);
      chk("fl_valid", 32'(OutValid), 32'd0);
      chk("fl_ctrl_kept", 32'(ALUCtrl), 32'h2);
      chk("fl_inready", 32'(InReady), 32'd1);
      for (int k = 0; k < 5; k++) begin
         @(negedge CLK);
         sample();
         chk("fl_no_result", 32'(OutValid), 32'd0);
      end
      @(negedge CLK);

      // ---- Flush on the MUL completion edge, with input offered ----
      present_mul();
      sample();
      @(negedge CLK);
      InValid = 1'b0;
      sample();
      @(negedge CLK);
      sample();
      @(negedge CLK);
      Flush   = 1'b1;
      InValid = 1'b1;
      ALUop   = 2'b10;
      Opcode  = OPC_ADD;
      sample();
      chk("flc_inready", 32'(InReady), 32'd0);
      @(negedge CLK);
      Flush   = 1'b0;
      InValid = 1'b0;
      sample();
      chk("flc_valid", 32'(OutValid), 32'd0);
      chk("flc_busy", 32'(Busy), 32'd0);
      @(negedge CLK);

      // ---- reset in the middle of MUL ----
      present_mul();
      sample();
      @(negedge CLK);
      InValid = 1'b0;
      sample();
      chk("rm_busy", 32'(Busy), 32'd1);
      Reset_L = 1'b0;
      #1;
      chk("rm_busy_clr", 32'(Busy), 32'd0);
      chk("rm_ctrl", 32'(ALUCtrl), 32'd1);
      chk("rm_inready", 32'(InReady), 32'd0);
      @(negedge CLK);
      Reset_L = 1'b1;
      sample();
      chk("rm_rel_inready", 32'(InReady), 32'd1);
      @(negedge CLK);
      sample();
      chk("rm_no_result", 32'(OutValid), 32'd0);
      chk("rm_rel_busy", 32'(Busy), 32'd0);

      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
